// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: the core (read/write) and a peripheral (read only)
// share one synchronous-read data memory through an IDLE -> ACC -> RESP sequence.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  // Handshake (both requesters): req rises and stays high, with address/data stable,
  // until the one-cycle ack pulse; the requester drops req the cycle after ack.
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          per_req,
  input  logic [AW-1:0] per_addr,
  output logic          per_ack,
  output logic [DW-1:0] per_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] per_rdata_q, per_rdata_d;
  logic          load;
  logic          win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      per_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      per_rdata_q <= per_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    per_rdata_d = per_rdata_q;
    load        = 1'b0;
    win         = owner_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || per_req) begin
          load    = 1'b1;
          // On a tie the side not served last wins; otherwise the lone requester.
          win     = (cpu_req && per_req) ? ~owner_q : per_req;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!owner_q && !we_q) cpu_rdata_d = mem_rdata;
        if (owner_q)           per_rdata_d = mem_rdata;
        // The owner's own req is ignored here so the waiting side always gets the next slot.
        if ((!owner_q && per_req) || (owner_q && cpu_req)) begin
          load    = 1'b1;
          win     = ~owner_q;
          state_d = ST_ACC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      owner_d = win;
      addr_d  = win ? per_addr : cpu_addr;
      wdata_d = cpu_wdata;
      we_d    = ~win & cpu_we;
    end
  end

  assign mem_we    = (state_q == ST_ACC) && !owner_q && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant     = owner_q;
  assign cpu_ack   = (state_q == ST_RESP) && !owner_q;
  assign per_ack   = (state_q == ST_RESP) && owner_q;
  // Write acks leave cpu_rdata at the last read value rather than exposing stale memory data.
  assign cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : cpu_rdata_q;
  assign per_rdata = per_ack ? mem_rdata : per_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table for single accesses, then hand-written
// sequences for tie-break after reset, continuous alternation and reset during a write.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        per_req, per_ack;
  logic [31:0] per_addr, per_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, grant;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:255];
  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .per_req(per_req), .per_addr(per_addr), .per_ack(per_ack), .per_rdata(per_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant(grant), .dbg_state(dbg_state)
  );

  // Synchronous-read memory: data for the address presented this cycle appears next cycle.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, creq, cwe;
    logic [31:0] caddr, cwd;
    logic        preq;
    logic [31:0] paddr;
    logic        busy, grant, cack, pack, mwe;
    logic [31:0] maddr, mwd, crd, prd;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    per_req = 0; per_addr = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    reset = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr;
    cpu_wdata = v.cwd; per_req = v.preq; per_addr = v.paddr;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d_busy", i),    {31'd0, busy},    {31'd0, v.busy});
    chk($sformatf("v%0d_grant", i),   {31'd0, grant},   {31'd0, v.grant});
    chk($sformatf("v%0d_cpu_ack", i), {31'd0, cpu_ack}, {31'd0, v.cack});
    chk($sformatf("v%0d_per_ack", i), {31'd0, per_ack}, {31'd0, v.pack});
    chk($sformatf("v%0d_mem_we", i),  {31'd0, mem_we},  {31'd0, v.mwe});
    chk($sformatf("v%0d_mem_addr", i),  mem_addr,  v.maddr);
    chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v.mwd);
    chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, v.crd);
    chk($sformatf("v%0d_per_rdata", i), per_rdata, v.prd);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] PD = 32'h12345678;

  initial begin
    logic c_done, p_done, exp_c, exp_p;
    int acks;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h20] = PD;
    mem_rdata = 32'h0;
    reset = 1'b1;
    drive_idle();

    // rst creq cwe caddr cwd preq paddr | busy grant cack pack mwe maddr mwd crd prd
    vecs.push_back('{1,0,0,32'h00,32'h0,0,32'h00, 0,1,0,0,0,32'h00,32'h0,32'h0,32'h0});
    vecs.push_back('{0,0,0,32'h00,32'h0,0,32'h00, 0,1,0,0,0,32'h00,32'h0,32'h0,32'h0});
    vecs.push_back('{0,1,1,32'h40,DB,   0,32'h00, 0,1,0,0,0,32'h00,32'h0,32'h0,32'h0});
    vecs.push_back('{0,1,1,32'h40,DB,   0,32'h00, 1,0,0,0,1,32'h40,DB,   32'h0,32'h0});
    vecs.push_back('{0,1,1,32'h40,DB,   0,32'h00, 1,0,1,0,0,32'h40,DB,   32'h0,32'h0});
    vecs.push_back('{0,0,0,32'h00,32'h0,0,32'h00, 0,0,0,0,0,32'h40,DB,   32'h0,32'h0});
    vecs.push_back('{0,0,0,32'h00,32'h0,1,32'h80, 0,0,0,0,0,32'h40,DB,   32'h0,32'h0});
    vecs.push_back('{0,0,0,32'h00,32'h0,1,32'h80, 1,1,0,0,0,32'h80,32'h0,32'h0,32'h0});
    vecs.push_back('{0,0,0,32'h00,32'h0,1,32'h80, 1,1,0,1,0,32'h80,32'h0,32'h0,PD});
    vecs.push_back('{0,0,0,32'h00,32'h0,0,32'h00, 0,1,0,0,0,32'h80,32'h0,32'h0,PD});
    vecs.push_back('{0,1,0,32'h40,32'h0,0,32'h00, 0,1,0,0,0,32'h80,32'h0,32'h0,PD});
    vecs.push_back('{0,1,0,32'h40,32'h0,0,32'h00, 1,0,0,0,0,32'h40,32'h0,32'h0,PD});
    vecs.push_back('{0,1,0,32'h40,32'h0,0,32'h00, 1,0,1,0,0,32'h40,32'h0,DB,   PD});
    vecs.push_back('{0,0,0,32'h00,32'h0,0,32'h00, 0,0,0,0,0,32'h40,32'h0,DB,   PD});

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply_vec(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // Simultaneous requests right after reset: core first, peripheral two cycles later.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_grant", {31'd0, grant}, 32'd1);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    c_done = 0; p_done = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        per_req = 1; per_addr = 32'h80;
      end
      if (c_done) cpu_req = 0;
      if (p_done) per_req = 0;
      #1;
      exp_c = (cyc == 3);
      exp_p = (cyc == 5);
      chk($sformatf("tie_c%0d_cpu_ack", cyc), {31'd0, cpu_ack}, {31'd0, exp_c});
      chk($sformatf("tie_c%0d_per_ack", cyc), {31'd0, per_ack}, {31'd0, exp_p});
      if (cyc >= 2 && cyc <= 5)
        chk($sformatf("tie_c%0d_grant", cyc), {31'd0, grant}, (cyc >= 4) ? 32'd1 : 32'd0);
      if (cyc == 3) chk("tie_cpu_rdata", cpu_rdata, DB);
      if (cyc == 5) chk("tie_per_rdata", per_rdata, PD);
      if (cyc == 6) chk("tie_idle_busy", {31'd0, busy}, 32'd0);
      if (cpu_ack) c_done = 1;
      if (per_ack) p_done = 1;
    end

    // Both requesters held continuously: eight acks alternating, one every two cycles.
    acks = 0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        per_req = 1; per_addr = 32'h80;
      end
      if (cyc == 17) begin
        cpu_req = 0; per_req = 0;
      end
      #1;
      exp_c = (cyc >= 3) && (cyc % 2 == 1) && (((cyc - 3) / 2) % 2 == 0);
      exp_p = (cyc >= 3) && (cyc % 2 == 1) && (((cyc - 3) / 2) % 2 == 1);
      chk($sformatf("alt_c%0d_cpu_ack", cyc), {31'd0, cpu_ack}, {31'd0, exp_c});
      chk($sformatf("alt_c%0d_per_ack", cyc), {31'd0, per_ack}, {31'd0, exp_p});
      if (exp_c) chk($sformatf("alt_c%0d_cpu_rdata", cyc), cpu_rdata, DB);
      if (exp_p) chk($sformatf("alt_c%0d_per_rdata", cyc), per_rdata, PD);
      if (cpu_ack || per_ack) acks++;
    end
    chk("alt_ack_count", acks, 32'd8);
    chk("alt_end_busy", {31'd0, busy}, 32'd0);

    // Reset asserted mid-ACC of a core write: write aborted asynchronously, no ack.
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'hCAFEF00D;
    #1;
    chk("rw_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #1;
    chk("rw_acc_mem_we", {31'd0, mem_we}, 32'd1);
    chk("rw_acc_mem_addr", mem_addr, 32'h44);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rw_rst_busy", {31'd0, busy}, 32'd0);
    chk("rw_rst_grant", {31'd0, grant}, 32'd1);
    chk("rw_rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rw_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    #1;
    chk("rw_mem_unwritten", mem[8'h11], 32'h0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rw_post_c%0d_cpu_ack", cyc), {31'd0, cpu_ack}, 32'd0);
      chk($sformatf("rw_post_c%0d_busy", cyc), {31'd0, busy}, 32'd0);
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
